simple_cpu: RTL and testbench
=============================

# simple_cpu

Minimal 16-bit accumulator CPU (`SimpleCPU`) that fetches and executes instructions from a 256×16 unified instruction/data memory (`InstructionMemory`) over a single-port bus. It executes each instruction in two clock cycles and is the core of the SimpleCPU subsystem. The memory sits outside the core; the testbench or top level wires the two together.

## Interface
Parameters:
- `ADDR_W`, 8: bus address width (memory depth 2^ADDR_W).
- `DATA_W`, 16: word and instruction width.

Ports (SimpleCPU):
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `data_out`  in  16  read data returned by memory for `address`.
- `rw_enable`  out  1  bus direction: 1 = read, 0 = write.
- `address`  out  8  bus address.
- `data_in`  out  16  write data to memory (accumulator).
- `acc`  out  16  accumulator, for debug/verification.
- `halted`  out  1  high once HLT has executed.

Ports (InstructionMemory): `clk`, `rw_enable`, `address[7:0]`, `data_in[15:0]` in; `data_out[15:0]` out.

## Operation
- Instruction format: `[15:12]` opcode, `[11:8]` ignored, `[7:0]` operand `a` (immediate or address).
- Opcodes:
  - 0 LDI: acc = zext(a).
  - 1 LD: acc = mem[a].
  - 2 ST: mem[a] = acc.
  - 3 ADD: acc += mem[a].
  - 4 SUB: acc -= mem[a].
  - 5 AND with mem[a].
  - 6 OR with mem[a].
  - 7 XOR with mem[a].
  - 8 JMP: pc = a.
  - 9 JZ: pc = a if acc == 0.
  - A JNZ: pc = a if acc != 0.
  - B ADDI: acc += zext(a).
  - F HLT.
  - C–E: NOP.
- Arithmetic is modulo 2^16: no flags, carry and borrow discarded.
- State machine: FETCH → EXEC → FETCH.
  - FETCH: address = pc, rw_enable = 1. On the edge: ir ← data_out, pc ← pc+1 (wraps 0xFF→0x00).
  - EXEC: address = ir[7:0]. rw_enable = 0 only for ST, otherwise 1. data_in = acc. On the edge: update acc/pc, then return to FETCH.
  - EXEC with HLT: enter HALT. HALT holds all state, drives address = pc and rw_enable = 1, and is left only by reset.
- `address`, `rw_enable` and `data_in` are combinational from state, pc, ir and acc.
- InstructionMemory:
  - `data_out = mem[address]` is a combinational read.
  - When rw_enable = 0, mem[address] ← data_in on the rising edge.
  - No reset; contents survive CPU reset. Simulation initial contents are all zero.

## Timing
- Reset (reset = 0 at an edge) sets pc = 0, ir = 0, acc = 0, state = FETCH, halted = 0.
- During reset the outputs are address = 0x00, rw_enable = 1, data_in = 0x0000, so the CPU never writes while in reset.
- Every instruction takes exactly 2 cycles. Its result is visible on `acc` the cycle after the EXEC edge.
- First fetch happens on the first edge with reset = 1. The first instruction's result appears after the 2nd such edge.
- Reset asserted in any state, including mid-EXEC or HALT, wins at that edge. An ST in EXEC at the same edge as reset is not written.
- A jump taken to a + fall-through is never fetched (no pipeline). The next FETCH uses the new pc.
- pc wraps at 0xFF to 0x00. An operand address of 0xFF is valid.
- An ST to the address of a not-yet-fetched instruction modifies the program (self-modifying code allowed).

## Structure
- Shared package `simple_cpu_pkg` holds:
  - opcode localparams (OP_LDI … OP_HLT);
  - state enum FETCH/EXEC/HALT;
  - ADDR_W/DATA_W defaults.
- The core has no sub-module; ALU and decode are inline case logic.
- `instruction_memory` is a separate natural module (256×16 register array, synchronous write, asynchronous read), instantiated beside the core at top level.

## Test plan
- **Write then read memory:** address 0x00, data_in 0x000A, rw_enable 0 for one edge, then rw_enable 1 → memory data_out = 0x000A.
- **First instruction after reset:** mem[0] = 0x000A, reset low 2 edges then high → after 2 edges acc = 0x000A and address = 0x01 in FETCH.
- **Memory operations:** program LDI 5; ST 0x80; LDI 0; LD 0x80; ADDI 3 → mem[0x80] = 0x0005 and final acc = 0x0008. rw_enable is low exactly one cycle.
- **Wraparound and branch:** mem[0x90] = 0xFFFF; program LDI 1; ADD 0x90; JZ 0x20 → acc = 0x0000 and pc = 0x20. The JNZ variant with acc nonzero jumps; with acc = 0 it falls through.
- **Halt:** program LDI 7; HLT → halted = 1, acc = 7, address and acc stable for 10+ cycles. Reset clears halted and refetches from 0x00.
- **Reset mid-instruction:** assert reset during the EXEC of an ST → memory unchanged, pc = 0 and acc = 0 next cycle, and program memory contents are retained.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the SimpleCPU subsystem: opcodes, FSM states and
// default bus widths.
package simple_cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_memory.sv
// Unified instruction/data store for SimpleCPU: asynchronous read,
// synchronous write when rw_enable is low. Contents are not reset.
module instruction_memory
  import simple_cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rw_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (!rw_enable) begin
      mem[address] <= data_in;
    end
  end

  assign data_out = mem[address];

endmodule

// File: rtl/simple_cpu.sv
// Two-cycle accumulator CPU core (FETCH -> EXEC) driving a single-port
// unified memory bus. ALU and decode are inline.
module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_out,
  output logic              rw_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] acc,
  output logic              halted
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] ir, acc_nxt;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] opnd_zext;
  logic              unused_ir;

  assign opcode    = ir[DATA_W-1 -: 4];
  assign opnd      = ir[ADDR_W-1:0];
  assign opnd_zext = {{(DATA_W-ADDR_W){1'b0}}, opnd};
  assign unused_ir = ^ir[DATA_W-5:ADDR_W];

  // All arithmetic wraps modulo 2^DATA_W; carries and borrows are dropped.
  function automatic logic [DATA_W-1:0] alu(input logic [3:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] m,
                                            input logic [DATA_W-1:0] imm);
    case (op)
      OP_LDI:  alu = imm;
      OP_LD:   alu = m;
      OP_ADD:  alu = a + m;
      OP_SUB:  alu = a - m;
      OP_AND:  alu = a & m;
      OP_OR:   alu = a | m;
      OP_XOR:  alu = a ^ m;
      OP_ADDI: alu = a + imm;
      default: alu = a;
    endcase
  endfunction

  always_comb begin
    acc_nxt = alu(opcode, acc, data_out, opnd_zext);
    pc_nxt  = pc;
    case (opcode)
      OP_JMP:  pc_nxt = opnd;
      OP_JZ:   if (acc == '0) pc_nxt = opnd;
      OP_JNZ:  if (acc != '0) pc_nxt = opnd;
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = (opcode == OP_HLT) ? HALT : FETCH;
      default: state_nxt = HALT;
    endcase
  end

  // Bus outputs are forced idle while reset is low so a pending ST never lands.
  always_comb begin
    rw_enable = 1'b1;
    address   = pc;
    data_in   = acc;
    halted    = (state == HALT);
    if (!reset) begin
      address = '0;
      data_in = '0;
    end else if (state == EXEC) begin
      address   = opnd;
      rw_enable = (opcode != OP_ST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir <= data_out;
          pc <= pc + ADDR_W'(1);
        end
        EXEC: begin
          acc <= acc_nxt;
          pc  <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// Bench for simple_cpu wired to instruction_memory; stores seen on the bus
// are checked in order against a scoreboard of expected writes.
module tb_simple_cpu;
  import simple_cpu_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_out, data_in, acc, mem_din, mem_dout;
  logic          rw_enable, halted, mem_rw;
  logic [AW-1:0] address, mem_addr;
  logic          tb_load = 1'b1;
  logic          tb_rw = 1'b1;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_din = '0;

  int total = 0;
  int bad = 0;
  int wr_cycles = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [3:0]  op;
    logic [15:0] acc0;
    logic [15:0] opnd;
    logic [15:0] exp;
  } vec_t;
  localparam int NV = 12;
  vec_t vec[NV];

  simple_cpu #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .data_out(data_out), .rw_enable(rw_enable),
    .address(address), .data_in(data_in), .acc(acc), .halted(halted)
  );

  instruction_memory #(.ADDR_W(AW), .DATA_W(DW)) u_mem (
    .clk(clk), .rw_enable(mem_rw), .address(mem_addr),
    .data_in(mem_din), .data_out(mem_dout)
  );

  assign mem_rw   = tb_load ? tb_rw   : rw_enable;
  assign mem_addr = tb_load ? tb_addr : address;
  assign mem_din  = tb_load ? tb_din  : data_in;
  assign data_out = mem_dout;

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (!tb_load && reset && rw_enable === 1'b0) begin
      wr_cycles++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL store_unexpected: got addr=%0h data=%0h want no store", address, data_in);
      end else begin
        e = sb.pop_front();
        chk("store_addr", 32'(address), 32'(e.addr));
        chk("store_data", 32'(data_in), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_addr = a;
    tb_din  = d;
    tb_rw   = 1'b0;
    tick();
    tb_rw   = 1'b1;
  endtask

  task automatic mem_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    tb_addr = a;
    #1;
    d = mem_dout;
  endtask

  task automatic enter_load();
    reset   = 1'b0;
    tb_load = 1'b1;
    tick();
    tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem_wr(AW'(i), '0);
  endtask

  task automatic start_run();
    tb_load = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int bound);
    for (int c = 0; c < bound && !halted; c++) tick();
    chk({name, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int w0;

    // reset state
    tick();
    tick();
    chk("rst_address", 32'(address), 32'h0);
    chk("rst_rw", 32'(rw_enable), 32'h1);
    chk("rst_data_in", 32'(data_in), 32'h0);
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // memory write then read
    mem_wr(8'h00, 16'h000A);
    mem_rd(8'h00, d);
    chk("mem_wr_rd0", 32'(d), 32'h000A);
    mem_wr(8'hFF, 16'hBEEF);
    mem_rd(8'hFF, d);
    chk("mem_wr_rdFF", 32'(d), 32'hBEEF);

    // first instruction after reset
    clear_mem();
    mem_wr(8'h00, 16'h000A);
    enter_load();
    start_run();
    tick();
    chk("first_exec_addr", 32'(address), 32'h0A);
    tick();
    chk("first_acc", 32'(acc), 32'h000A);
    chk("first_fetch_addr", 32'(address), 32'h01);
    chk("first_fetch_rw", 32'(rw_enable), 32'h1);

    // ALU table: each vector runs LD init; OP; ST result
    vec[0]  = '{OP_ADD,  16'h1234, 16'h1111, 16'h2345};
    vec[1]  = '{OP_ADD,  16'hFFFF, 16'h0002, 16'h0001};
    vec[2]  = '{OP_SUB,  16'h0005, 16'h0007, 16'hFFFE};
    vec[3]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF};
    vec[4]  = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030};
    vec[5]  = '{OP_OR,   16'hF000, 16'h000F, 16'hF00F};
    vec[6]  = '{OP_XOR,  16'hAAAA, 16'hFFFF, 16'h5555};
    vec[7]  = '{OP_ADDI, 16'hFFFE, 16'h0003, 16'h0001};
    vec[8]  = '{OP_LDI,  16'h1234, 16'h00AB, 16'h00AB};
    vec[9]  = '{OP_LD,   16'h5555, 16'h0F0F, 16'h0F0F};
    vec[10] = '{4'hC,    16'h4321, 16'h9999, 16'h4321};
    vec[11] = '{4'hE,    16'h0001, 16'h9999, 16'h0001};
    enter_load();
    clear_mem();
    for (int i = 0; i < NV; i++) begin
      logic [AW-1:0] a_init, a_opnd, a_res, opf;
      a_init = AW'(8'h80 + i);
      a_opnd = AW'(8'hA0 + i);
      a_res  = AW'(8'hC0 + i);
      mem_wr(a_init, vec[i].acc0);
      if (vec[i].op == OP_LDI || vec[i].op == OP_ADDI) begin
        opf = vec[i].opnd[AW-1:0];
      end else begin
        opf = a_opnd;
        mem_wr(a_opnd, vec[i].opnd);
      end
      mem_wr(AW'(3*i),     {OP_LD, 4'h0, a_init});
      mem_wr(AW'(3*i + 1), {vec[i].op, 4'h0, opf});
      mem_wr(AW'(3*i + 2), {OP_ST, 4'h0, a_res});
      sb.push_back('{a_res, vec[i].exp});
    end
    mem_wr(AW'(3*NV), {OP_HLT, 12'h000});
    start_run();
    run_to_halt("alu_table", 300);
    chk("alu_table_acc", 32'(acc), 32'(vec[NV-1].exp));
    chk("alu_table_drain", sb.size(), 0);

    // memory operations
    enter_load();
    clear_mem();
    mem_wr(8'h00, 16'h0005);
    mem_wr(8'h01, 16'h2080);
    mem_wr(8'h02, 16'h0000);
    mem_wr(8'h03, 16'h1080);
    mem_wr(8'h04, 16'hB003);
    mem_wr(8'h05, 16'hF000);
    sb.push_back('{8'h80, 16'h0005});
    w0 = wr_cycles;
    start_run();
    run_to_halt("memops", 100);
    chk("memops_acc", 32'(acc), 32'h0008);
    chk("memops_wr_cycles", wr_cycles - w0, 1);
    chk("memops_drain", sb.size(), 0);
    enter_load();
    mem_rd(8'h80, d);
    chk("memops_mem80", 32'(d), 32'h0005);

    // wraparound add then JZ taken
    clear_mem();
    mem_wr(8'h90, 16'hFFFF);
    mem_wr(8'h00, 16'h0001);
    mem_wr(8'h01, 16'h3090);
    mem_wr(8'h02, 16'h9020);
    mem_wr(8'h03, 16'h0077);
    mem_wr(8'h04, 16'hF000);
    mem_wr(8'h20, 16'hF000);
    start_run();
    run_to_halt("jz", 100);
    chk("jz_acc", 32'(acc), 32'h0000);
    chk("jz_pc", 32'(address), 32'h21);

    // JNZ fall-through, pc wrap 0xFF->0x00, JNZ taken, ST to 0xFF
    enter_load();
    clear_mem();
    mem_wr(8'h00, 16'hA010);
    mem_wr(8'h01, 16'h80FE);
    mem_wr(8'hFE, 16'h0004);
    mem_wr(8'hFF, 16'hB001);
    mem_wr(8'h10, 16'h20FF);
    mem_wr(8'h11, 16'hF000);
    sb.push_back('{8'hFF, 16'h0005});
    start_run();
    run_to_halt("wrap", 100);
    chk("wrap_acc", 32'(acc), 32'h0005);
    chk("wrap_pc", 32'(address), 32'h12);
    chk("wrap_drain", sb.size(), 0);
    enter_load();
    mem_rd(8'hFF, d);
    chk("wrap_memFF", 32'(d), 32'h0005);

    // halt holds state; reset clears it and refetches from 0
    clear_mem();
    mem_wr(8'h00, 16'h0007);
    mem_wr(8'h01, 16'hF000);
    start_run();
    run_to_halt("halt", 100);
    chk("halt_acc", 32'(acc), 32'h0007);
    chk("halt_addr", 32'(address), 32'h02);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("halt_hold_acc", 32'(acc), 32'h0007);
      chk("halt_hold_addr", 32'(address), 32'h02);
      chk("halt_hold_flag", 32'(halted), 32'h1);
    end
    reset = 1'b0;
    tick();
    chk("halt_rst_flag", 32'(halted), 32'h0);
    chk("halt_rst_acc", 32'(acc), 32'h0);
    reset = 1'b1;
    #1;
    chk("halt_refetch_addr", 32'(address), 32'h00);
    tick();
    tick();
    chk("halt_refetch_acc", 32'(acc), 32'h0007);
    chk("halt_refetch_pc", 32'(address), 32'h01);

    // reset during EXEC of an ST
    enter_load();
    clear_mem();
    mem_wr(8'h00, 16'h0009);
    mem_wr(8'h01, 16'h2050);
    mem_wr(8'h02, 16'hF000);
    mem_wr(8'h50, 16'h1234);
    w0 = wr_cycles;
    start_run();
    tick();
    tick();
    tick();
    chk("midrst_st_rw", 32'(rw_enable), 32'h0);
    chk("midrst_st_addr", 32'(address), 32'h50);
    reset = 1'b0;
    #1;
    chk("midrst_rw_blocked", 32'(rw_enable), 32'h1);
    tick();
    chk("midrst_acc", 32'(acc), 32'h0000);
    reset = 1'b1;
    #1;
    chk("midrst_pc", 32'(address), 32'h00);
    reset   = 1'b0;
    tb_load = 1'b1;
    tick();
    mem_rd(8'h50, d);
    chk("midrst_mem50", 32'(d), 32'h1234);
    mem_rd(8'h01, d);
    chk("midrst_prog_kept", 32'(d), 32'h2050);
    chk("midrst_no_store", wr_cycles - w0, 0);

    chk("final_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
